// File: rtl/rv32i_inst_wb_prefetch.sv
// Instruction-fetch front end: issues sequential pipelined Wishbone reads and
// buffers returned words with their PCs for the core's valid/ready fetch port.
module rv32i_inst_wb_prefetch #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       DEPTH     = 4,
    parameter int unsigned       MAX_OUTST = 2,
    parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                redirect_i,
    input  logic [ADDR_W-1:0]   redirect_pc_i,
    input  logic                inst_ready_i,
    output logic                inst_valid_o,
    output logic [DATA_W-1:0]   inst_o,
    output logic [ADDR_W-1:0]   inst_pc_o,
    output logic                inst_err_o,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    output logic                wb_we_o,
    output logic [ADDR_W-1:0]   wb_adr_o,
    output logic [DATA_W-1:0]   wb_dat_o,
    output logic [DATA_W/8-1:0] wb_sel_o,
    input  logic                wb_stall_i,
    input  logic                wb_ack_i,
    input  logic                wb_err_i,
    input  logic [DATA_W-1:0]   wb_dat_i
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_OUTST);
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    logic [ADDR_W-1:0] fetch_pc;
    logic              halted;
    logic [CNT_W-1:0]  outst;
    logic [CNT_W-1:0]  drop;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  pcq_rd;
    logic [PTR_W-1:0]  pcq_wr;

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [ADDR_W-1:0] mem_pc   [DEPTH];
    logic              mem_err  [DEPTH];
    logic [ADDR_W-1:0] pcq_mem  [DEPTH];

    logic              issue;
    logic              accept;
    logic              resp;
    logic              dropping;
    logic              push;
    logic              pop;
    logic [CNT_W:0]    credit_used;
    logic [CNT_W-1:0]  outst_next;

    // Credit counts buffered words plus every in-flight request, so the FIFO
    // always has room for whatever the bus still owes us.
    assign credit_used = {1'b0, fifo_cnt} + {1'b0, outst};
    assign issue       = !halted && (outst < MAX_C) && (credit_used < DEPTH_C);
    assign accept      = issue && !wb_stall_i;
    assign resp        = wb_ack_i || wb_err_i;
    assign dropping    = (drop != '0);
    assign push        = resp && !dropping && !redirect_i;
    assign pop         = inst_valid_o && inst_ready_i && !redirect_i;
    assign outst_next  = outst + CNT_W'(accept) - CNT_W'(resp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC & ALIGN_MASK;
            halted   <= 1'b0;
            outst    <= '0;
            drop     <= '0;
            fifo_cnt <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            pcq_rd   <= '0;
            pcq_wr   <= '0;
        end else begin
            outst <= outst_next;
            if (redirect_i) begin
                // Everything still owed by the bus, including a request
                // accepted right now, becomes stale and is discarded on return.
                fetch_pc <= redirect_pc_i & ALIGN_MASK;
                halted   <= 1'b0;
                drop     <= outst_next;
                fifo_cnt <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                pcq_rd   <= '0;
                pcq_wr   <= '0;
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + ADDR_W'(4);
                    pcq_wr   <= pcq_wr + PTR_W'(1);
                end
                if (resp) begin
                    if (dropping) begin
                        drop <= drop - CNT_W'(1);
                    end else begin
                        pcq_rd <= pcq_rd + PTR_W'(1);
                        wr_ptr <= wr_ptr + PTR_W'(1);
                        if (wb_err_i) begin
                            halted <= 1'b1;
                        end
                    end
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= wb_dat_i;
            mem_pc[wr_ptr]   <= pcq_mem[pcq_rd];
            mem_err[wr_ptr]  <= wb_err_i;
        end
        if (accept && !redirect_i) begin
            pcq_mem[pcq_wr] <= fetch_pc;
        end
    end

    assign inst_valid_o = (fifo_cnt != '0);
    assign inst_o       = inst_valid_o ? mem_data[rd_ptr] : '0;
    assign inst_pc_o    = inst_valid_o ? mem_pc[rd_ptr]   : '0;
    assign inst_err_o   = inst_valid_o ? mem_err[rd_ptr]  : 1'b0;

    assign wb_stb_o = rst_n && issue;
    assign wb_cyc_o = rst_n && (issue || (outst != '0));
    assign wb_we_o  = 1'b0;
    assign wb_adr_o = fetch_pc & ALIGN_MASK;
    assign wb_dat_o = '0;
    assign wb_sel_o = '1;

endmodule

// File: tb/tb_rv32i_inst_wb_prefetch.sv
// Directed bench for rv32i_inst_wb_prefetch with an in-order pipelined
// Wishbone slave model (one-cycle response latency, optional hold/error).
module tb_rv32i_inst_wb_prefetch;

    logic        clk;
    logic        rst_n;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        inst_ready_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_err_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stall_i;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic [31:0] wb_dat_i;

    rv32i_inst_wb_prefetch #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .DEPTH     (4),
        .MAX_OUTST (2),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .inst_ready_i  (inst_ready_i),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .inst_pc_o     (inst_pc_o),
        .inst_err_o    (inst_err_o),
        .wb_cyc_o      (wb_cyc_o),
        .wb_stb_o      (wb_stb_o),
        .wb_we_o       (wb_we_o),
        .wb_adr_o      (wb_adr_o),
        .wb_dat_o      (wb_dat_o),
        .wb_sel_o      (wb_sel_o),
        .wb_stall_i    (wb_stall_i),
        .wb_ack_i      (wb_ack_i),
        .wb_err_i      (wb_err_i),
        .wb_dat_i      (wb_dat_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        stall;
        logic        exp_stb;
        logic [31:0] exp_adr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t        vecs [10];
    logic [31:0] pend [$];
    logic        hold_resp;
    logic [31:0] err_addr;
    int unsigned n_cmp;
    int unsigned n_bad;
    int unsigned acc_count;

    function automatic logic [31:0] dfun(input logic [31:0] a);
        return 32'hA500_0000 ^ a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_slave();
        logic [31:0] h;
        if (pend.size() > 0 && !hold_resp) begin
            h        = pend[0];
            wb_err_i = (h == err_addr);
            wb_ack_i = (h != err_addr);
            wb_dat_i = dfun(h);
        end else begin
            wb_err_i = 1'b0;
            wb_ack_i = 1'b0;
            wb_dat_i = 32'h0;
        end
    endtask

    task automatic tick();
        logic        acc;
        logic        rsp;
        logic [31:0] a;
        acc = wb_stb_o && !wb_stall_i;
        a   = wb_adr_o;
        rsp = wb_ack_i || wb_err_i;
        @(posedge clk);
        #1;
        if (rsp && pend.size() > 0) void'(pend.pop_front());
        if (acc) begin
            pend.push_back(a);
            acc_count++;
        end
        drive_slave();
    endtask

    task automatic assert_reset(input string tag);
        rst_n         = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        inst_ready_i  = 1'b0;
        wb_stall_i    = 1'b0;
        hold_resp     = 1'b0;
        err_addr      = 32'hFFFF_FFFF;
        pend.delete();
        drive_slave();
        #1;
        check({tag, "_rst_stb"},   wb_stb_o,     0);
        check({tag, "_rst_cyc"},   wb_cyc_o,     0);
        check({tag, "_rst_valid"}, inst_valid_o, 0);
        check({tag, "_rst_inst"},  inst_o,       0);
        check({tag, "_rst_pc"},    inst_pc_o,    0);
        check({tag, "_rst_err"},   inst_err_o,   0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        acc_count = 0;
    endtask

    task automatic expect_next_pc(input string name, input logic [31:0] pc, input logic err);
        int unsigned n;
        n = 0;
        while (!inst_valid_o && n < 20) begin
            tick();
            n++;
        end
        check({name, "_valid"}, inst_valid_o, 1);
        if (inst_valid_o) begin
            check({name, "_pc"},   inst_pc_o,  pc);
            check({name, "_inst"}, inst_o,     dfun(pc));
            check({name, "_err"},  inst_err_o, err);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        acc_count = 0;

        // stream + 3-cycle stall on 0x8, ready held high
        vecs[0] = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
        vecs[1] = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
        vecs[2] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
        vecs[3] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h04};
        vecs[4] = '{1'b1, 1'b1, 32'h08, 1'b0, 32'h00};
        vecs[5] = '{1'b0, 1'b1, 32'h08, 1'b0, 32'h00};
        vecs[6] = '{1'b0, 1'b1, 32'h0C, 1'b0, 32'h00};
        vecs[7] = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h08};
        vecs[8] = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h0C};
        vecs[9] = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h10};

        assert_reset("t0");
        check("const_we",  wb_we_o,  0);
        check("const_sel", wb_sel_o, 4'hF);
        check("const_dat", wb_dat_o, 0);
        inst_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wb_stall_i = vecs[i].stall;
            #1;
            check($sformatf("vec%0d_stb", i),   wb_stb_o,     vecs[i].exp_stb);
            check($sformatf("vec%0d_cyc", i),   wb_cyc_o,     1);
            check($sformatf("vec%0d_adr", i),   wb_adr_o,     vecs[i].exp_adr);
            check($sformatf("vec%0d_valid", i), inst_valid_o, vecs[i].exp_valid);
            check($sformatf("vec%0d_pc", i),    inst_pc_o,    vecs[i].exp_pc);
            check($sformatf("vec%0d_inst", i),  inst_o,
                  vecs[i].exp_valid ? dfun(vecs[i].exp_pc) : 32'h0);
            check($sformatf("vec%0d_err", i),   inst_err_o,   0);
            tick();
        end
        wb_stall_i = 1'b0;

        // core not ready: credit limits to DEPTH requests
        assert_reset("t1");
        inst_ready_i = 1'b0;
        repeat (12) tick();
        check("fill_accepts", acc_count,    4);
        check("fill_stb",     wb_stb_o,     0);
        check("fill_valid",   inst_valid_o, 1);
        inst_ready_i = 1'b1;
        expect_next_pc("drain0", 32'h00, 1'b0);
        expect_next_pc("drain1", 32'h04, 1'b0);
        expect_next_pc("drain2", 32'h08, 1'b0);
        expect_next_pc("drain3", 32'h0C, 1'b0);
        expect_next_pc("drain4", 32'h10, 1'b0);

        // redirect with two outstanding requests
        assert_reset("t2");
        inst_ready_i = 1'b1;
        hold_resp    = 1'b1;
        drive_slave();
        tick();
        tick();
        check("outst_limit_stb", wb_stb_o, 0);
        check("outst_limit_cyc", wb_cyc_o, 1);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h100;
        tick();
        redirect_i = 1'b0;
        hold_resp  = 1'b0;
        drive_slave();
        check("drop_credit_stb", wb_stb_o,     0);
        check("drop_valid",      inst_valid_o, 0);
        check("drop_adr",        wb_adr_o,     32'h100);
        tick();
        check("redir_stb", wb_stb_o, 1);
        check("redir_adr", wb_adr_o, 32'h100);
        expect_next_pc("redir0", 32'h100, 1'b0);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h102;
        tick();
        redirect_i = 1'b0;
        check("redir_unal_valid", inst_valid_o, 0);
        check("redir_unal_adr",   wb_adr_o,     32'h100);
        expect_next_pc("redir_unal0", 32'h100, 1'b0);
        expect_next_pc("redir_unal1", 32'h104, 1'b0);

        // bus error on 0xC halts fetch until redirect
        assert_reset("t3");
        inst_ready_i = 1'b1;
        err_addr     = 32'h0C;
        expect_next_pc("err0", 32'h00, 1'b0);
        expect_next_pc("err1", 32'h04, 1'b0);
        expect_next_pc("err2", 32'h08, 1'b0);
        expect_next_pc("err3", 32'h0C, 1'b1);
        expect_next_pc("err4", 32'h10, 1'b0);
        check("halt_stb",   wb_stb_o,     0);
        check("halt_cyc",   wb_cyc_o,     0);
        check("halt_valid", inst_valid_o, 0);
        repeat (4) tick();
        check("halt_stb_late",   wb_stb_o,     0);
        check("halt_valid_late", inst_valid_o, 0);
        err_addr      = 32'hFFFF_FFFF;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h40;
        tick();
        redirect_i = 1'b0;
        check("resume_stb", wb_stb_o, 1);
        check("resume_adr", wb_adr_o, 32'h40);
        expect_next_pc("resume0", 32'h40, 1'b0);
        expect_next_pc("resume1", 32'h44, 1'b0);

        // redirect coinciding with an ack and a pop
        assert_reset("t4");
        inst_ready_i = 1'b1;
        tick();
        tick();
        tick();
        check("coinc_pre_valid", inst_valid_o, 1);
        check("coinc_pre_pc",    inst_pc_o,    32'h04);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h200;
        tick();
        redirect_i = 1'b0;
        check("coinc_valid0", inst_valid_o, 0);
        check("coinc_stb",    wb_stb_o,     1);
        check("coinc_adr",    wb_adr_o,     32'h200);
        tick();
        check("coinc_valid1", inst_valid_o, 0);
        expect_next_pc("coinc0", 32'h200, 1'b0);
        expect_next_pc("coinc1", 32'h204, 1'b0);

        // reset asserted while requests are in flight
        assert_reset("t5");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rv32i_inst_wb_prefetch.md
Name: rv32i_inst_wb_prefetch

Overview:
- Parametrised instruction-fetch front end; sits between the RV32I core fetch stage and a pipelined Wishbone (B4) instruction memory.
- Issues sequential word fetches with up to MAX_OUTST requests in flight and buffers returned words plus their PCs in a DEPTH-entry FIFO.
- Presents instructions to the core on a valid/ready handshake.
- Supports redirect/flush with discard of stale responses, and reports bus errors per instruction.

Parameters:
- ADDR_W, 32, address and PC width.
- DATA_W, 32, instruction word width; byte-lane count is DATA_W/8.
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- MAX_OUTST, 2, maximum accepted-but-unanswered requests; range 1..DEPTH.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- redirect_i  in  1  flush the FIFO and restart fetch at redirect_pc_i.
- redirect_pc_i  in  ADDR_W  new fetch PC; bits [1:0] ignored.
- inst_ready_i  in  1  core accepts the head entry.
- inst_valid_o  out  1  head entry valid.
- inst_o  out  DATA_W  instruction word.
- inst_pc_o  out  ADDR_W  PC of inst_o.
- inst_err_o  out  1  entry came from a wb_err_i response.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone cycle, strobe, write-enable.
- wb_adr_o  out  ADDR_W  word-aligned request address.
- wb_dat_o  out  DATA_W  constant 0.
- wb_sel_o  out  DATA_W/8  constant all-ones.
- wb_stall_i, wb_ack_i, wb_err_i  in  1 each  slave stall, acknowledge, error.
- wb_dat_i  in  DATA_W  read data.

Behaviour:
- Reset values: fetch_pc=RESET_PC; FIFO empty; outstanding=0; drop=0; halted=0.
- Outputs in reset: wb_cyc_o=0, wb_stb_o=0, inst_valid_o=0. inst_o, inst_pc_o and inst_err_o are forced to 0 whenever inst_valid_o=0.
- Constant outputs: wb_we_o=0, wb_dat_o=0, wb_sel_o all ones.
- Address: wb_adr_o = {fetch_pc[ADDR_W-1:2], 2'b00}, driven from registered state only.
- Issue condition: wb_stb_o=1 iff !halted AND outstanding<MAX_OUTST AND (fifo_count+outstanding)<DEPTH.
- The credit check guarantees no FIFO overflow.
- Request accept: wb_stb_o & !wb_stall_i. On accept, fetch_pc += 4 (wraps modulo 2^ADDR_W) and outstanding increments.
- Stalled request: address and strobe held stable unless a redirect occurs; a redirect may change the address while stalled.
- Response: wb_ack_i | wb_err_i, at most one per cycle; decrements outstanding.
  - If drop>0: response discarded, drop decrements.
  - Otherwise push {wb_dat_i, pc, wb_err_i}, where pc comes from an internal in-order PC queue of issued addresses.
- Error: a pushed err entry sets halted=1. No new requests until redirect; already-outstanding responses are still buffered.
- wb_cyc_o = wb_stb_o OR outstanding>0, including responses owed to drop.
- Core side: inst_valid_o = !empty. Pop on inst_valid_o & inst_ready_i.
- Latency: response in cycle N becomes visible as inst_valid_o at N+1. With a zero-wait slave, sustained throughput is 1 instruction/cycle.
- Simultaneous push and pop is allowed, including at full.
- Redirect, in the cycle redirect_i=1:
  - Next state: FIFO emptied, PC queue cleared, fetch_pc=redirect_pc_i & ~3, halted=0.
  - drop = outstanding_next, counting any request accepted this cycle minus any response received this cycle (that response is itself discarded).
  - outstanding tracks normally.
  - A pop in the same cycle is allowed and is superseded by the flush.
- First post-redirect request: in the cycle after redirect, if credit allows. Note that credit still counts drop-owed requests against MAX_OUTST.
- Empty + ready: no effect. Full: stb deasserts via credit.
- Reset mid-transaction returns everything to reset values immediately; the bus slave must also be reset.

Test Plan:
- Reset release, zero-wait slave, inst_ready_i=1 -> wb_adr_o 0x0, 0x4, 0x8… on consecutive cycles; inst_pc_o 0x0 with the first word one cycle after its ack; then 1 instr/cycle.
- inst_ready_i=0 with DEPTH=4, MAX_OUTST=2 -> exactly 4 requests accepted, stb low thereafter; FIFO drains 4 words in PC order once ready=1.
- wb_stall_i high 3 cycles on request 0x8 -> wb_adr_o held 0x8, no increment; resumes 0xC after release.
- Redirect to 0x100 with 2 outstanding -> both late acks discarded; next inst_pc_o=0x100; redirect_pc 0x102 also yields 0x100.
- wb_err_i on 0xC -> entry 0xC has inst_err_o=1; no further stb until redirect to 0x40, then fetch resumes at 0x40.
- Redirect in the same cycle as an ack and a pop -> that ack is dropped; FIFO empty next cycle; no spurious inst_valid_o.
